// File: rtl/sine_rom_sequencer.sv
// -----------------------------------------------------------------------------
// sine_rom_sequencer
//
// Phase-accumulator address generator for an external synchronous sine ROM.
// While running, it issues one ROM read every max(sample_div,1) clock cycles.
// Each read presents the top ADDR_W bits of the phase accumulator as the ROM
// address and then advances the phase by tuning_word. A token follows every
// read through a ROM_LATENCY+1 stage shift register. When the token leaves the
// register, the returned ROM word is captured into 'sample' and 'sample_valid'
// pulses for that one cycle.
//
// When enable drops, the block stops issuing reads and drains. Every read that
// is still in flight still produces its sample. The block returns to idle only
// after all in-flight reads have completed.
//
// Parameters
//   ADDR_W      ROM address width
//   DATA_W      ROM word / sample width
//   PHASE_W     phase accumulator width (must be >= ADDR_W)
//   ROM_LATENCY cycles from rom_address change to valid rom_q (1..4)
//   DIV_W       sample-rate divider width
//
// Ports
//   clock        in   single rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   level request to run
//   tuning_word  in   phase increment per sample (sampled on each read tick)
//   sample_div   in   clock cycles per sample, 0 treated as 1 (sampled on tick)
//   rom_address  out  address to the synchronous ROM, held between reads
//   rom_q        in   ROM read data
//   sample       out  last captured ROM word, held between updates
//   sample_valid out  one-cycle pulse when sample updates
//   busy         out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module sine_rom_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int PHASE_W     = 24,
    parameter int ROM_LATENCY = 2,
    parameter int DIV_W       = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [DIV_W-1:0]   sample_div,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [DATA_W-1:0]  rom_q,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               busy
);

    // One stage for the rom_address register plus the ROM's own latency.
    localparam int PIPE_D = ROM_LATENCY + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [PHASE_W-1:0] phase;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_reload;
    logic [PIPE_D-1:0]  token_pipe;
    logic               start;
    logic               read_tick;
    logic               in_flight;

    // A read happens on every RUN cycle that finds the divider at zero. The
    // cycle on which enable is seen low still counts as RUN. A tick that is
    // due on that cycle is issued before the FSM moves to DRAIN.
    assign start     = (state == ST_IDLE) && enable;
    assign read_tick = (state == ST_RUN) && (div_cnt == '0);
    assign in_flight = |token_pipe;
    assign busy      = (state != ST_IDLE);

    // sample_div of 0 behaves exactly like 1: reload 0, so a read every cycle.
    always_comb begin
        div_reload = '0;
        if (sample_div != '0) begin
            div_reload = sample_div - DIV_W'(1);
        end
    end

    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (enable)     state_next = ST_RUN;
            ST_RUN:   if (!enable)    state_next = ST_DRAIN;
            // enable is deliberately ignored here: a drain always completes.
            ST_DRAIN: if (!in_flight) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every always_ff
    // reads pre-edge values regardless of evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase accumulator and divider. Entering RUN clears both, so the first
    // RUN cycle always ticks at phase 0. tuning_word and sample_div are only
    // looked at on a tick. A change part-way through a period therefore
    // cannot stretch or shorten the period that is already counting down.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            div_cnt <= '0;
        end else if (start) begin
            phase   <= '0;
            div_cnt <= '0;
        end else if (read_tick) begin
            phase   <= phase + tuning_word;  // natural modulo-2^PHASE_W wrap
            div_cnt <= div_reload;
        end else if ((state == ST_RUN) && (div_cnt != '0)) begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    // Address register: changes only on a read tick, so the ROM sees a stable
    // address for the whole period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
        end else if (read_tick) begin
            rom_address <= phase[PHASE_W-1 -: ADDR_W];
        end
    end

    // Token pipe: bit k set means a read issued k+1 edges ago is in flight.
    // Several bits may be set at once when the sample period is shorter than
    // the pipe. Reset clears it, so aborted reads never produce a sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            token_pipe <= '0;
        end else begin
            token_pipe <= {token_pipe[PIPE_D-2:0], read_tick};
        end
    end

    // Capture stage: the oldest token lines up with the ROM output for the
    // address it was issued with.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= token_pipe[PIPE_D-1];
            if (token_pipe[PIPE_D-1]) begin
                sample <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_sine_rom_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sine_rom_sequencer
//
// Bench for sine_rom_sequencer. It provides a synchronous ROM model whose
// word encodes its own address, which makes every captured sample traceable
// to the address that produced it. A transaction-level reference model is
// kept alongside: a mode, a phase, a countdown, and a queue of pending reads
// with their due cycles. Outputs are compared against that model on every
// falling edge. Directed sections pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_sine_rom_sequencer;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;
    localparam int PHASE_W = 24;
    localparam int LAT     = 2;
    localparam int DIV_W   = 16;

    logic               clock       = 1'b0;
    logic               reset_n     = 1'b1;
    logic               enable      = 1'b0;
    logic [PHASE_W-1:0] tuning_word = '0;
    logic [DIV_W-1:0]   sample_div  = '0;
    logic [ADDR_W-1:0]  rom_address;
    logic [DATA_W-1:0]  rom_q;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic               busy;

    sine_rom_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PHASE_W(PHASE_W),
        .ROM_LATENCY(LAT), .DIV_W(DIV_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .tuning_word(tuning_word), .sample_div(sample_div),
        .rom_address(rom_address), .rom_q(rom_q),
        .sample(sample), .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    // ROM word = {address, 6'h2D}: the address can be read back from any sample.
    function automatic logic [DATA_W-1:0] rom_word(input int a);
        int w;
        w = (a % 1024) * 64 + 45;
        return w[DATA_W-1:0];
    endfunction

    // Synchronous ROM with LAT cycles of latency.
    logic [DATA_W-1:0] rq [LAT];
    always @(posedge clock) begin
        rq[0] <= rom_word(int'(rom_address));
        for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
    end
    assign rom_q = rq[LAT-1];

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
    typedef struct {
        longint due;
        int     addr;
    } rd_t;

    rd_t               pend[$];
    mode_t             m_mode   = M_IDLE;
    longint            m_phase  = 0;
    longint            m_left   = 0;
    int                m_addr   = 0;
    logic [DATA_W-1:0] m_sample = '0;
    bit                m_valid  = 1'b0;
    longint            m_cyc    = 0;
    bit                m_outstanding;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_IDLE; m_phase = 0; m_left = 0; m_addr = 0;
            m_sample = '0; m_valid = 1'b0; m_cyc = 0;
            pend.delete();
        end else begin
            m_cyc++;
            m_outstanding = (pend.size() != 0);
            m_valid = 1'b0;
            // A read issued at edge t delivers its sample at edge t+LAT+1.
            if (pend.size() != 0 && pend[0].due == m_cyc) begin
                m_sample = rom_word(pend[0].addr);
                m_valid  = 1'b1;
                void'(pend.pop_front());
            end
            case (m_mode)
                M_IDLE: if (enable) begin
                    m_mode = M_RUN; m_phase = 0; m_left = 0;
                end
                M_RUN: begin
                    if (m_left == 0) begin
                        m_addr = int'(m_phase >> (PHASE_W - ADDR_W));
                        pend.push_back('{due: m_cyc + LAT + 1, addr: m_addr});
                        m_phase = (m_phase + longint'(tuning_word)) % (longint'(1) << PHASE_W);
                        m_left  = (sample_div == 0) ? 0 : longint'(sample_div) - 1;
                    end else begin
                        m_left--;
                    end
                    if (!enable) m_mode = M_DRAIN;
                end
                M_DRAIN: if (!m_outstanding) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vq_data[$];
    int vq_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        check("model_addr",  64'(rom_address),  64'(m_addr));
        check("model_sample", 64'(sample),      64'(m_sample));
        check("model_valid", 64'(sample_valid), 64'(m_valid));
        check("model_busy",  64'(busy),         64'(m_mode != M_IDLE));
        if (sample_valid) begin
            vq_data.push_back(int'(sample));
            vq_cyc.push_back(cyc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain_to_idle();
        enable = 1'b0;
        run(LAT + 4);
    endtask

    task automatic clear_log();
        vq_data.delete();
        vq_cyc.delete();
    endtask

    initial begin
        int t0;
        int bad;
        int idle_cyc;
        int exp_a[5];

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("reset_addr",  64'(rom_address),  64'd0);
        check("reset_sample", 64'(sample),      64'd0);
        check("reset_valid", 64'(sample_valid), 64'd0);
        check("reset_busy",  64'(busy),         64'd0);
        run(2);
        reset_n = 1'b1;
        run(2);

        // Sweep: one address step per cycle, continuous samples
        clear_log();
        tuning_word = 24'(1 << 14);
        sample_div  = 16'd1;
        enable      = 1'b1;
        t0 = cyc;
        run(1040);
        check("sweep_count", 64'(vq_data.size() >= 1026), 64'd1);
        if (vq_cyc.size() > 0) check("sweep_first_latency", 64'(vq_cyc[0] - t0), 64'(LAT + 3));
        for (int i = 0; i < vq_data.size() && i < 1026; i++)
            check("sweep_word", 64'(vq_data[i]), 64'(rom_word(i)));
        bad = 0;
        for (int i = 1; i < vq_cyc.size() && i < 1026; i++)
            if (vq_cyc[i] - vq_cyc[i-1] != 1) bad++;
        check("sweep_gaps", 64'(bad), 64'd0);
        drain_to_idle();

        // Divider 5, then divider 0
        clear_log();
        sample_div = 16'd5;
        enable     = 1'b1;
        run(40);
        drain_to_idle();
        for (int i = 1; i < 5 && i < vq_cyc.size(); i++)
            check("div5_gap", 64'(vq_cyc[i] - vq_cyc[i-1]), 64'd5);
        clear_log();
        sample_div = 16'd0;
        enable     = 1'b1;
        run(20);
        drain_to_idle();
        for (int i = 1; i < 6 && i < vq_cyc.size(); i++)
            check("div0_gap", 64'(vq_cyc[i] - vq_cyc[i-1]), 64'd1);

        // Negative tuning word wraps downward
        clear_log();
        sample_div  = 16'd1;
        tuning_word = 24'hFFC000;
        enable      = 1'b1;
        run(12);
        drain_to_idle();
        exp_a = '{0, 1023, 1022, 1021, 1020};
        check("wrap_count", 64'(vq_data.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < vq_data.size(); i++)
            check("wrap_word", 64'(vq_data[i]), 64'(rom_word(exp_a[i])));

        // Drain: 10 ticks (the last one on the enable-low cycle)
        clear_log();
        tuning_word = 24'(1 << 14);
        sample_div  = 16'd1;
        enable      = 1'b1;
        run(10);
        enable   = 1'b0;
        idle_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!busy && idle_cyc < 0) idle_cyc = cyc;
        end
        check("drain_count", 64'(vq_data.size()), 64'd10);
        check("drain_addr_frozen", 64'(rom_address), 64'd9);
        if (vq_cyc.size() > 0) check("drain_busy_fall", 64'(idle_cyc - vq_cyc[$]), 64'd1);

        // Reset with reads in flight
        clear_log();
        enable = 1'b1;
        run(8);
        reset_n = 1'b0;
        #1;
        check("rst_addr",  64'(rom_address),  64'd0);
        check("rst_sample", 64'(sample),      64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_busy",  64'(busy),         64'd0);
        enable = 1'b0;
        run(2);
        reset_n = 1'b1;
        clear_log();
        run(10);
        check("rst_quiet", 64'(vq_data.size()), 64'd0);
        enable = 1'b1;
        run(8);
        drain_to_idle();
        if (vq_data.size() > 0) check("rst_restart_word", 64'(vq_data[0]), 64'(rom_word(0)));
        else check("rst_restart_word", 64'd0, 64'(rom_word(0)));

        // Retune mid-period at sample_div=4
        clear_log();
        sample_div  = 16'd4;
        tuning_word = 24'(1 << 14);
        enable      = 1'b1;
        run(7);                       // ticks at edges 2 and 6, now mid-period
        tuning_word = 24'(1 << 15);
        run(20);
        drain_to_idle();
        exp_a = '{0, 1, 2, 4, 6};
        check("retune_count", 64'(vq_data.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < vq_data.size(); i++)
            check("retune_word", 64'(vq_data[i]), 64'(rom_word(exp_a[i])));
        for (int i = 1; i < 5 && i < vq_cyc.size(); i++)
            check("retune_gap", 64'(vq_cyc[i] - vq_cyc[i-1]), 64'd4);

        // Randomized traffic with occasional asynchronous resets
        for (int it = 0; it < 80; it++) begin
            tuning_word = PHASE_W'($urandom);
            sample_div  = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 20))
                                                      : DIV_W'($urandom_range(0, 4));
            enable      = ($urandom_range(0, 3) != 0);
            run($urandom_range(3, 40));
            if ($urandom_range(0, 9) == 0) begin
                #($urandom_range(1, 4));
                reset_n = 1'b0;
                run(2);
                reset_n = 1'b1;
            end
        end
        drain_to_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sine_rom_sequencer.md
SINE_ROM_SEQUENCER -- requirements
Module: sine_rom_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, ROM address width (1024 entries).
REQ-002 Parameter DATA_W, default 16, ROM word and sample width.
REQ-003 Parameter PHASE_W, default 24, phase accumulator width; PHASE_W SHALL be >= ADDR_W.
REQ-004 Parameter ROM_LATENCY, default 2, cycles from rom_address change to valid rom_q; legal range 1..4.
REQ-005 Parameter DIV_W, default 16, sample-rate divider width.
REQ-006 clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 enable  in  1  level request to run the sequencer.
REQ-009 tuning_word  in  PHASE_W  phase increment per sample.
REQ-010 sample_div  in  DIV_W  clock cycles per sample; 0 SHALL be treated as 1.
REQ-011 rom_address  out  ADDR_W  address to the synchronous sine ROM.
REQ-012 rom_q  in  DATA_W  ROM read data.
REQ-013 sample  out  DATA_W  last captured ROM word, held between updates.
REQ-014 sample_valid  out  1  one-cycle pulse when sample updates.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-017 IDLE -> RUN when enable=1; on this transition phase SHALL clear to 0 and the divider counter SHALL clear to 0.
REQ-018 RUN -> DRAIN when enable=0; DRAIN -> IDLE when no read is outstanding; DRAIN -> RUN SHALL NOT occur (enable in DRAIN ignored until IDLE).
REQ-019 In RUN, a read tick SHALL occur on each cycle the divider counter equals 0; counter then reloads max(sample_div,1)-1, otherwise decrements.
REQ-020 First read tick SHALL occur on the first cycle in RUN.
REQ-021 On a read tick, rom_address SHALL register phase[PHASE_W-1 -: ADDR_W] and phase SHALL update to phase + tuning_word modulo 2^PHASE_W (natural wrap, no saturation).
REQ-022 tuning_word and sample_div SHALL be sampled on the tick/reload cycle; changes take effect from the next tick without glitching the current period.
REQ-023 Each read tick SHALL launch a token in a ROM_LATENCY+1 stage shift register (1 cycle for the rom_address register plus ROM_LATENCY).
REQ-024 When a token exits, sample SHALL register rom_q and sample_valid SHALL pulse for exactly that cycle.
REQ-025 Every issued read SHALL produce exactly one sample_valid, including reads in flight when enable falls; no reads SHALL issue in DRAIN or IDLE.
REQ-026 With sample_div <= ROM_LATENCY multiple tokens SHALL be in flight concurrently; back-to-back sample_valid SHALL be supported at sample_div=1.
REQ-027 rom_address SHALL hold its value outside read ticks.

Reset
REQ-028 On reset_n=0, immediately and asynchronously: state=IDLE, phase=0, divider=0, token pipe=0, rom_address=0, sample=0, sample_valid=0, busy=0.
REQ-029 Reset asserted mid-RUN or mid-DRAIN SHALL discard all in-flight tokens; no sample_valid SHALL follow reset release until a new read is issued.
REQ-030 After reset_n rises, operation SHALL resume from IDLE on the first rising edge with enable=1.

Verification
REQ-031 Sweep: sample_div=1, tuning_word=2^14, enable 1024+ cycles -> rom_address steps 0,1,...,1023,0; sample equals ROM[n] ROM_LATENCY+1 cycles after address n; sample_valid continuous.
REQ-032 Divider: sample_div=5, tuning_word=2^14 -> sample_valid exactly every 5 cycles; sample_div=0 behaves identically to 1.
REQ-033 Wrap: tuning_word=0xFFC000 (-2^14) from phase 0 -> addresses 0,1023,1022,...; phase wraps without error.
REQ-034 Drain: sample_div=1, drop enable after 10 ticks -> exactly 10 sample_valid pulses total, busy falls the cycle after the last token leaves, rom_address frozen.
REQ-035 Reset mid-run: assert reset_n=0 with 3 tokens in flight -> all outputs 0 at once, zero sample_valid after release; re-enable restarts at rom_address=0.
REQ-036 Retune: change tuning_word from 2^14 to 2^15 mid-period at sample_div=4 -> current period unaffected, next address increments by 2.
